gcd_stream_core: RTL and testbench

//  Parametrised, handshaked GCD engine; successor to the fixed 8-bit switch/LED GCD datapath.

---
 rtl/gcd_stream_core_pkg.sv | 20 ++
 rtl/gcd_stream_core_operand_cond.sv | 22 ++
 rtl/gcd_stream_core.sv | 164 ++++++++++++++++
 tb/tb_gcd_stream_core.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/gcd_stream_core_pkg.sv
// Shared definitions for the handshaked GCD engine: FSM state encoding,
// algorithm selectors and a saturating-increment helper.
package gcd_stream_core_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  localparam int ALGO_SUB   = 0;
  localparam int ALGO_STEIN = 1;

  // Generic so it can serve any counter width without a per-width copy.
  function automatic logic [31:0] sat_inc(input logic [31:0] value, input logic [31:0] max_value);
    return (value >= max_value) ? max_value : value + 32'd1;
  endfunction

endpackage

// File: rtl/gcd_stream_core_operand_cond.sv
// Combinational operand conditioning: converts a raw operand pair to unsigned
// magnitudes (two's complement when SIGNED_IN=1) and flags zero operands.
module gcd_operand_cond #(
  parameter int WIDTH     = 8,
  parameter int SIGNED_IN = 1
) (
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output logic [WIDTH-1:0] o_mag_a,
  output logic [WIDTH-1:0] o_mag_b,
  output logic             o_a_zero,
  output logic             o_b_zero
);

  // The most negative value negates onto itself, whose unsigned reading is
  // exactly its magnitude, so no extra bit is needed.
  assign o_mag_a  = ((SIGNED_IN != 0) && i_a[WIDTH-1]) ? -i_a : i_a;
  assign o_mag_b  = ((SIGNED_IN != 0) && i_b[WIDTH-1]) ? -i_b : i_b;
  assign o_a_zero = (i_a == '0);
  assign o_b_zero = (i_b == '0);

endmodule

// File: rtl/gcd_stream_core.sv
// Handshaked iterative GCD engine: captures an operand pair, reduces it by
// subtractive Euclid or binary Stein, and reports |gcd| with an iteration count.
module gcd_stream_core
  import gcd_stream_core_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int SIGNED_IN = 1,
  parameter int ALGO      = 1,
  parameter int CNT_W     = 8
) (
  input  logic             CLOCK_125_p,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] gcd_out,
  output logic [CNT_W-1:0] cycles_out,
  output logic             err_zero,
  output logic             busy
);

  localparam int K_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [31:0] CNT_MAX = 32'((64'd1 << CNT_W) - 64'd1);

  state_t           r_state;
  state_t           w_state_next;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [K_W-1:0]   r_k;
  logic [CNT_W-1:0] r_count;
  logic [WIDTH-1:0] r_gcd;
  logic [CNT_W-1:0] r_cycles;
  logic             r_err_zero;

  logic [WIDTH-1:0] w_mag_a;
  logic [WIDTH-1:0] w_mag_b;
  logic             w_a_zero;
  logic             w_b_zero;
  logic             w_accept;
  logic             w_run_done;
  logic [WIDTH-1:0] w_run_gcd;
  logic [WIDTH-1:0] w_a_step;
  logic [WIDTH-1:0] w_b_step;
  logic [K_W-1:0]   w_k_step;
  logic [CNT_W-1:0] w_count_inc;

  // In LOAD, r_a/r_b still hold the raw captured operands.
  gcd_operand_cond #(
    .WIDTH    (WIDTH),
    .SIGNED_IN(SIGNED_IN)
  ) u_operand_cond (
    .i_a     (r_a),
    .i_b     (r_b),
    .o_mag_a (w_mag_a),
    .o_mag_b (w_mag_b),
    .o_a_zero(w_a_zero),
    .o_b_zero(w_b_zero)
  );

  assign w_accept    = in_valid && (r_state == ST_IDLE);
  assign w_run_done  = (ALGO == ALGO_SUB) ? (r_b == '0) : (r_a == '0);
  assign w_run_gcd   = (ALGO == ALGO_SUB) ? r_a : (r_b << r_k);
  assign w_count_inc = CNT_W'(sat_inc(32'(r_count), CNT_MAX));

  assign in_ready   = (r_state == ST_IDLE);
  assign out_valid  = (r_state == ST_DONE);
  assign busy       = (r_state == ST_LOAD) || (r_state == ST_RUN);
  assign gcd_out    = r_gcd;
  assign cycles_out = r_cycles;
  assign err_zero   = r_err_zero;

  // NOTE: every signal driven here gets a default first so no path leaves it
  // unassigned; a missing default would infer a latch.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE: if (w_accept) w_state_next = ST_LOAD;
      ST_LOAD: w_state_next = (w_a_zero || w_b_zero) ? ST_DONE : ST_RUN;
      ST_RUN:  if (w_run_done) w_state_next = ST_DONE;
      ST_DONE: if (out_ready) w_state_next = ST_IDLE;
      default: w_state_next = ST_IDLE;
    endcase
  end

  // One reduction step; the compares guard each subtraction against underflow.
  always_comb begin
    w_a_step = r_a;
    w_b_step = r_b;
    w_k_step = r_k;
    if (ALGO == ALGO_SUB) begin
      if (r_a > r_b) w_a_step = r_a - r_b;
      else           w_b_step = r_b - r_a;
    end else begin
      if (!r_a[0] && !r_b[0]) begin
        w_a_step = r_a >> 1;
        w_b_step = r_b >> 1;
        w_k_step = r_k + K_W'(1);
      end else if (!r_a[0]) begin
        w_a_step = r_a >> 1;
      end else if (!r_b[0]) begin
        w_b_step = r_b >> 1;
      end else if (r_a >= r_b) begin
        w_a_step = r_a - r_b;
      end else begin
        w_b_step = r_b - r_a;
      end
    end
  end

  // NOTE: registered state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge CLOCK_125_p or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_next;
  end

  always_ff @(posedge CLOCK_125_p or negedge rst_n) begin
    if (!rst_n) begin
      r_a        <= '0;
      r_b        <= '0;
      r_k        <= '0;
      r_count    <= '0;
      r_gcd      <= '0;
      r_cycles   <= '0;
      r_err_zero <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_a <= a_in;
            r_b <= b_in;
          end
        end
        ST_LOAD: begin
          r_a        <= w_mag_a;
          r_b        <= w_mag_b;
          r_k        <= '0;
          r_count    <= '0;
          r_err_zero <= w_a_zero && w_b_zero;
          if (w_a_zero || w_b_zero) begin
            r_gcd    <= w_a_zero ? w_mag_b : w_mag_a;
            r_cycles <= '0;
          end
        end
        ST_RUN: begin
          if (w_run_done) begin
            r_gcd    <= w_run_gcd;
            r_cycles <= r_count;
          end else begin
            r_a     <= w_a_step;
            r_b     <= w_b_step;
            r_k     <= w_k_step;
            r_count <= w_count_inc;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_gcd_stream_core.sv
// Self-checking bench: Stein, subtractive and narrow-counter subtractive cores
// share one operand stream and are checked against an arithmetic gcd model.
module tb_gcd_stream_core;

  localparam int N = 3;  // 0: Stein, 1: subtractive, 2: subtractive with 3-bit counter

  logic                clk;
  logic                rst_n;
  logic                in_valid;
  logic [7:0]          a_in;
  logic [7:0]          b_in;
  logic [N-1:0]        in_ready;
  logic [N-1:0]        out_valid;
  logic [N-1:0]        out_ready;
  logic [N-1:0]        err_zero;
  logic [N-1:0]        busy;
  logic [N-1:0][7:0]   gcd;
  logic [1:0][7:0]     cyc_full;
  logic [2:0]          cyc_sat;

  int checks = 0;
  int errors = 0;

  gcd_stream_core #(.WIDTH(8), .SIGNED_IN(1), .ALGO(1), .CNT_W(8)) u_stein (
    .CLOCK_125_p(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready[0]),
    .a_in(a_in), .b_in(b_in), .out_valid(out_valid[0]), .out_ready(out_ready[0]),
    .gcd_out(gcd[0]), .cycles_out(cyc_full[0]), .err_zero(err_zero[0]), .busy(busy[0]));

  gcd_stream_core #(.WIDTH(8), .SIGNED_IN(1), .ALGO(0), .CNT_W(8)) u_sub (
    .CLOCK_125_p(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready[1]),
    .a_in(a_in), .b_in(b_in), .out_valid(out_valid[1]), .out_ready(out_ready[1]),
    .gcd_out(gcd[1]), .cycles_out(cyc_full[1]), .err_zero(err_zero[1]), .busy(busy[1]));

  gcd_stream_core #(.WIDTH(8), .SIGNED_IN(1), .ALGO(0), .CNT_W(3)) u_sat (
    .CLOCK_125_p(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready[2]),
    .a_in(a_in), .b_in(b_in), .out_valid(out_valid[2]), .out_ready(out_ready[2]),
    .gcd_out(gcd[2]), .cycles_out(cyc_sat), .err_zero(err_zero[2]), .busy(busy[2]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, actual, expected);
    end
  endtask

  function automatic int mag(input logic [7:0] v);
    return v[7] ? 256 - int'(v) : int'(v);
  endfunction

  function automatic int ref_gcd(input int x, input int y);
    int t;
    while (y != 0) begin
      t = x % y;
      x = y;
      y = t;
    end
    return x;
  endfunction

  // Repeated subtraction of the smaller from the larger costs the quotient
  // of each Euclidean division step.
  function automatic int ref_sub_cycles(input int x, input int y);
    int hi, lo, r, s;
    if (x == 0 || y == 0) return 0;
    hi = (x > y) ? x : y;
    lo = (x > y) ? y : x;
    s  = 0;
    while (lo != 0) begin
      s += hi / lo;
      r  = hi % lo;
      hi = lo;
      lo = r;
    end
    return s;
  endfunction

  function automatic int sat7(input int v);
    return (v > 7) ? 7 : v;
  endfunction

  task automatic wait_all_ready(output bit ok);
    int n = 0;
    while (in_ready != '1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    ok = (in_ready == '1);
    if (!ok) check("ready_timeout", 0, 1);
  endtask

  task automatic transact(input logic [7:0] a, input logic [7:0] b,
                          output logic [N-1:0][7:0] g, output logic [N-1:0][7:0] c,
                          output logic [N-1:0] e, output bit ok);
    int n;
    wait_all_ready(ok);
    g = '0; c = '0; e = '0;
    if (!ok) return;
    a_in = a; b_in = b; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    n = 0;
    while (out_valid != '1 && n < 600) begin
      @(negedge clk);
      n++;
    end
    if (out_valid != '1) begin
      check("done_timeout", int'(out_valid), 7);
      ok = 1'b0;
    end
    g = gcd;
    c[0] = cyc_full[0];
    c[1] = cyc_full[1];
    c[2] = {5'd0, cyc_sat};
    e = err_zero;
    out_ready = '1;
    @(negedge clk);
    out_ready = '0;
  endtask

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    int         g;
    int         cs;
    int         cu;
    int         ez;
  } vec_t;

  vec_t vecs[8];

  initial begin
    logic [N-1:0][7:0] g;
    logic [N-1:0][7:0] c;
    logic [N-1:0]      e;
    bit                ok;
    int                ea, eb, eg, ec;
    bit                seen;

    vecs[0] = '{8'hEC, 8'd50, 10, 6, 4, 0};
    vecs[1] = '{8'd0,  8'd0,  0,  0, 0, 1};
    vecs[2] = '{8'h80, 8'd64, 64, 8, 2, 0};
    vecs[3] = '{8'd0,  8'hF9, 7,  0, 0, 0};
    vecs[4] = '{8'd13, 8'd13, 13, 1, 1, 0};
    vecs[5] = '{8'd7,  8'd0,  7,  0, 0, 0};
    vecs[6] = '{8'd48, 8'd18, 6,  7, 5, 0};
    vecs[7] = '{8'h80, 8'h80, 128, 8, 1, 0};

    rst_n = 1'b0; in_valid = 1'b0; out_ready = '0; a_in = '0; b_in = '0;
    repeat (3) @(negedge clk);
    check("rst_in_ready", int'(in_ready), 7);
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_gcd", int'(gcd), 0);
    check("rst_err", int'(err_zero), 0);
    check("rst_cycles", int'({cyc_full, cyc_sat}), 0);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_in_ready", int'(in_ready), 7);

    for (int i = 0; i < 8; i++) begin
      transact(vecs[i].a, vecs[i].b, g, c, e, ok);
      for (int d = 0; d < N; d++) begin
        check($sformatf("vec%0d_gcd_dut%0d", i, d), int'(g[d]), vecs[i].g);
        check($sformatf("vec%0d_err_dut%0d", i, d), int'(e[d]), vecs[i].ez);
      end
      check($sformatf("vec%0d_cyc_stein", i), int'(c[0]), vecs[i].cs);
      check($sformatf("vec%0d_cyc_sub", i), int'(c[1]), vecs[i].cu);
      check($sformatf("vec%0d_cyc_sat", i), int'(c[2]), sat7(vecs[i].cu));
    end

    for (int i = 0; i < 40; i++) begin
      logic [7:0] ra, rb;
      ra = 8'($urandom_range(0, 255));
      rb = 8'($urandom_range(0, 255));
      if (i % 10 == 3) ra = 8'd0;
      ea = mag(ra); eb = mag(rb);
      eg = ref_gcd(ea, eb);
      ec = ref_sub_cycles(ea, eb);
      transact(ra, rb, g, c, e, ok);
      for (int d = 0; d < N; d++)
        check($sformatf("rnd%0d_gcd_dut%0d", i, d), int'(g[d]), eg);
      check($sformatf("rnd%0d_err", i), int'(e[0]), (ea == 0 && eb == 0) ? 1 : 0);
      check($sformatf("rnd%0d_cyc_sub", i), int'(c[1]), ec);
      check($sformatf("rnd%0d_cyc_sat", i), int'(c[2]), sat7(ec));
    end

    // Zero pair: result appears two edges after the accepting edge.
    wait_all_ready(ok);
    a_in = 8'd0; b_in = 8'd0; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    check("zero_lat_load_valid", int'(out_valid[0]), 0);
    check("zero_lat_load_busy", int'(busy[0]), 1);
    @(negedge clk);
    check("zero_lat_done_valid", int'(out_valid[0]), 1);
    check("zero_lat_err", int'(err_zero[0]), 1);
    out_ready = '1;
    @(negedge clk);
    out_ready = '0;

    // Backpressure: result held, new operands ignored while DONE.
    wait_all_ready(ok);
    a_in = 8'd35; b_in = 8'd21; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    for (int n = 0; n < 100 && out_valid != '1; n++) @(negedge clk);
    check("bp_reached_done", int'(out_valid), 7);
    for (int n = 0; n < 10; n++) begin
      a_in = 8'd9; b_in = 8'd3; in_valid = 1'b1;
      @(negedge clk);
      check($sformatf("bp_hold%0d_valid", n), int'(out_valid[0]), 1);
      check($sformatf("bp_hold%0d_gcd", n), int'(gcd[0]), 7);
      check($sformatf("bp_hold%0d_ready", n), int'(in_ready), 0);
    end
    in_valid = 1'b0;
    out_ready = '1;
    @(negedge clk);
    out_ready = '0;
    check("bp_release_valid", int'(out_valid), 0);
    check("bp_release_ready", int'(in_ready), 7);
    transact(8'd42, 8'd56, g, c, e, ok);
    check("bp_next_gcd", int'(g[0]), 14);
    check("bp_next_cyc_sub", int'(c[1]), ref_sub_cycles(42, 56));

    // Asynchronous reset in the middle of a long subtractive run.
    wait_all_ready(ok);
    a_in = 8'd1; b_in = 8'd127; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (4) @(negedge clk);
    check("mid_run_busy", int'(busy[1]), 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_busy", int'(busy), 0);
    check("async_rst_gcd", int'(gcd), 0);
    check("async_rst_valid", int'(out_valid), 0);
    check("async_rst_ready", int'(in_ready), 7);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    for (int n = 0; n < 200; n++) begin
      @(negedge clk);
      if (out_valid != '0) seen = 1'b1;
    end
    check("post_rst_no_valid", int'(seen), 0);
    check("post_rst_ready", int'(in_ready), 7);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
